seg7_serial_display: RTL and testbench
======================================

Name: seg7_serial_display

Overview:
- Parametrised driver for a chain of 74HC595-style shift registers behind an N-digit 7-segment display.
- Decodes per-digit hex nibbles, decimal points and blank masks into segment bits, and captures them into a shadow frame register.
- Serialises the frame onto ser/sclk, then pulses rclk to latch the outputs.
- Supports one-shot frames on a load strobe or continuous refresh. Used by debug/status displays clocked from eclk.

Parameters:
- DIGITS, 6, number of digits; frame is 8*DIGITS bits.
- CLKDIV, 32, eclk cycles per serial bit and per rclk pulse. Must be even and >= 2.
- CONTINUOUS, 0. 1 = frames restart back-to-back and load is ignored; 0 = a frame runs only on load.
- SEG_INVERT, 1. 1 = ser carries the inverted segment bit (common-anode); 0 = true bit.

Ports:
- eclk  input  1  emulation clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- hex  input  4*DIGITS  digit values; nibble i = digit i, digit 0 rightmost.
- dp  input  DIGITS  decimal point per digit, 1 = lit.
- blank  input  DIGITS  1 = all segments and dp of that digit off.
- load  input  1  frame start request, sampled every eclk.
- busy  output  1  high while a frame is shifting or latching.
- frame_done  output  1  one-cycle pulse at the end of each frame.
- rclk  output  1  register latch clock.
- sclk  output  1  shift clock.
- ser  output  1  serial data.

Behaviour:
- Reset (async, reset=0): state IDLE; busy=0, frame_done=0, rclk=0, sclk=0, ser=0, pending=0; counters and shadow register = 0.
- Segment byte per digit: bit0..6 = a..g, bit7 = dp.
  - Hex font: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - blank forces the byte to 00.
- Frame bit order: digit DIGITS-1 first, bit7 first within each digit; bit 0 of digit 0 is shifted last.
- ser = byte bit XOR SEG_INVERT.
- States: IDLE, SHIFT, LATCH.
- IDLE -> SHIFT:
  - Trigger: load=1 when CONTINUOUS=0; the cycle after reset release when CONTINUOUS=1.
  - On that edge: decode hex/dp/blank into shadow, busy<=1, ser<=first bit, sclk<=0, bit counter=0, divider=0.
- SHIFT:
  - Divider counts 0..CLKDIV-1 per bit.
  - sclk=0 while divider < CLKDIV/2 and sclk=1 from CLKDIV/2 to CLKDIV-1, so the rising edge falls mid-bit.
  - ser is stable for all CLKDIV cycles of its bit.
  - At divider wrap, advance to the next bit and set sclk<=0.
  - After bit 8*DIGITS-1, go to LATCH.
- LATCH:
  - rclk=1 and sclk=0 for CLKDIV cycles; ser holds the last bit.
  - Then rclk<=0 and frame_done<=1 for exactly one cycle.
  - Next state: SHIFT if pending=1 or CONTINUOUS=1 (new shadow captured on that same edge, frame_done still pulses), else IDLE with busy<=0.
- Frame length: (8*DIGITS+1)*CLKDIV cycles; back-to-back frames have no gap cycles.
- load while busy (CONTINUOUS=0): sets pending. Multiple loads collapse into one pending frame, which samples inputs when it starts, not when load was asserted. pending clears when that frame starts.
- Inputs that change during a frame do not affect the frame in flight.
- reset asserted mid-frame: outputs return to reset values immediately and the partial frame is abandoned. The external latch keeps its old contents because rclk never pulsed.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero blanking is applied at shadow capture. Starting from digit DIGITS-1 and moving down, each digit whose nibble is 0 is blanked until the first nonzero nibble. Digit 0 is never blanked by this rule. dp on a blanked digit is also suppressed. The explicit blank input still applies.
- Not defined: zero digits are always shown as 3F (subject to blank); no extra logic.

Test Plan:
1. DIGITS=2, CLKDIV=4, SEG_INVERT=0, hex=0x1A, dp=00, blank=00, one load pulse:
   - ser sequence is 06 then 77, MSB first.
   - 16 sclk rising edges, each 2 cycles after its bit starts.
   - rclk high for 4 cycles; frame_done pulses at cycle 68 after load; busy low afterwards.
2. SEG_INVERT=1, hex=0x88, dp=10, blank=01:
   - Shifted bytes are FF and 00, which appear on ser inverted as 00 and FF.
3. load asserted 3 times during a frame with hex changed to 0x23 mid-frame:
   - The current frame still shows the old data.
   - Exactly one further frame follows with 5B,4F and no gap.
   - busy stays high continuously; frame_done pulses twice.
4. CONTINUOUS=1, load held 0:
   - Frames repeat every 68 cycles with busy constantly 1.
   - A hex change appears starting with the next frame.
5. reset pulled low at bit 9 of a frame:
   - All outputs are 0 within the same cycle with no rclk pulse.
   - After release, a load produces a full clean frame.
6. SEG7_LZ_BLANK_EN defined, DIGITS=4, hex=0x0050, dp=1111:
   - Bytes are 00, 00, ED (5 with dp), BF (0 with dp).
   - hex=0x0000 gives 00, 00, 00, BF.

Source files
------------

// File: rtl/seg7_serial_display.sv
// seg7_serial_display
//   Drives a chain of 74HC595-style shift registers that sit behind an
//   N-digit 7-segment display. Each frame decodes the hex nibbles, decimal
//   points and blank mask into segment bytes, snapshots them into a shadow
//   register, shifts them out MSB first (digit DIGITS-1 first) on ser/sclk
//   and then holds rclk high for CLKDIV cycles to latch the outputs.
//
// Parameters
//   DIGITS     number of digits, frame is 8*DIGITS bits
//   CLKDIV     eclk cycles per serial bit and per rclk pulse (even, >= 2)
//   CONTINUOUS 1 = back-to-back frames, load ignored; 0 = frame per load
//   SEG_INVERT 1 = ser carries inverted segment bits (common anode)
//
// Ports
//   eclk        in   clock, rising edge
//   reset       in   asynchronous, active-low reset
//   hex         in   4*DIGITS digit nibbles, nibble 0 = rightmost digit
//   dp          in   DIGITS decimal points, 1 = lit
//   blank       in   DIGITS blank mask, 1 = digit fully dark
//   load        in   frame start request
//   busy        out  high while shifting or latching
//   frame_done  out  one-cycle pulse at the end of every frame
//   rclk        out  storage register latch clock
//   sclk        out  shift clock
//   ser         out  serial data
//
// Optional feature
//   Define SEG7_LZ_BLANK_EN to blank leading zero digits at shadow capture
//   (digit 0 is always shown; dp of a blanked digit is suppressed too).

module seg7_serial_display #(
  parameter int DIGITS     = 6,
  parameter int CLKDIV     = 32,
  parameter int CONTINUOUS = 0,
  parameter int SEG_INVERT = 1
) (
  input  logic                  eclk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  rclk,
  output logic                  sclk,
  output logic                  ser
);

  localparam int FW = 8 * DIGITS;
  localparam int BW = $clog2(FW);
  localparam int DW = $clog2(CLKDIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLKDIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
  localparam logic          INV      = (SEG_INVERT != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [FW-1:0]  shadow_q, shadow_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [DW-1:0]  div_q, div_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           rclk_q, rclk_d;
  logic           sclk_q, sclk_d;
  logic           ser_q, ser_d;
  logic           pending_q, pending_d;
  logic           start;
  logic [FW-1:0]  frame_word;
  logic [3:0]     nib;
  logic [7:0]     seg_byte;
`ifdef SEG7_LZ_BLANK_EN
  logic           leading;
`endif

  // Segment font, bit0..6 = a..g.
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      default: font = 7'h71;
    endcase
  endfunction

  // Builds the frame that would be captured if a frame started this cycle.
  // Walks from the leftmost digit down so leading-zero blanking can track
  // whether a nonzero digit has been seen yet.
  always_comb begin
    frame_word = '0;
    nib        = 4'h0;
    seg_byte   = 8'h00;
`ifdef SEG7_LZ_BLANK_EN
    leading    = 1'b1;
`endif
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib      = hex[4*d +: 4];
      seg_byte = {dp[d], font(nib)};
`ifdef SEG7_LZ_BLANK_EN
      if (d != 0 && leading && nib == 4'h0) begin
        seg_byte = 8'h00;
      end else begin
        leading = 1'b0;
      end
`endif
      if (blank[d]) begin
        seg_byte = 8'h00;
      end
      frame_word[8*d +: 8] = seg_byte;
    end
  end

  // Next-state and output logic. The shadow register shifts left once per
  // bit so its MSB is always the bit on ser; sclk rises when the divider
  // reaches its midpoint so the shift register samples a settled ser.
  // A frame start (from IDLE or straight out of LATCH) overrides whatever
  // the state branch chose, which is what makes back-to-back frames gapless.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bit_d     = bit_q;
    div_d     = div_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rclk_d    = rclk_q;
    sclk_d    = sclk_q;
    ser_d     = ser_q;
    pending_d = pending_q;
    start     = 1'b0;

    case (state_q)
      IDLE: begin
        if (CONTINUOUS != 0 || load) begin
          start = 1'b1;
        end
      end
      SHIFT: begin
        if (CONTINUOUS == 0 && load) begin
          pending_d = 1'b1;
        end
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = LATCH;
            rclk_d  = 1'b1;
          end else begin
            bit_d    = bit_q + 1'b1;
            shadow_d = {shadow_q[FW-2:0], 1'b0};
            ser_d    = shadow_d[FW-1] ^ INV;
          end
        end else begin
          div_d  = div_q + 1'b1;
          sclk_d = (div_d >= DIV_HALF);
        end
      end
      LATCH: begin
        if (CONTINUOUS == 0 && load) begin
          pending_d = 1'b1;
        end
        if (div_q == DIV_LAST) begin
          rclk_d = 1'b0;
          done_d = 1'b1;
          if (pending_d || CONTINUOUS != 0) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            div_d   = '0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      state_d   = SHIFT;
      shadow_d  = frame_word;
      ser_d     = frame_word[FW-1] ^ INV;
      sclk_d    = 1'b0;
      rclk_d    = 1'b0;
      bit_d     = '0;
      div_d     = '0;
      busy_d    = 1'b1;
      pending_d = 1'b0;
    end
  end

  // State register. Reset abandons any partial frame without pulsing rclk,
  // so the external latch keeps showing the previous frame.
  always_ff @(posedge eclk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rclk_q    <= 1'b0;
      sclk_q    <= 1'b0;
      ser_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rclk_q    <= rclk_d;
      sclk_q    <= sclk_d;
      ser_q     <= ser_d;
      pending_q <= pending_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign rclk       = rclk_q;
  assign sclk       = sclk_q;
  assign ser        = ser_q;

endmodule

// File: tb/tb_seg7_serial_display.sv
// tb_seg7_serial_display
//   Directed bench for seg7_serial_display. Four instances cover the
//   one-shot true-polarity case, the inverted case, continuous refresh and
//   a 4-digit display for the leading-zero option.

module tb_seg7_serial_display;

  logic eclk = 1'b0;
  always #5 eclk = ~eclk;

  logic reset;

  logic [7:0]  hex0, hex1, hex2;
  logic [15:0] hex3;
  logic [1:0]  dp0, dp1, dp2, blank0, blank1, blank2;
  logic [3:0]  dp3, blank3;
  logic        load0, load1, load2, load3;
  logic        busy0, busy1, busy2, busy3;
  logic        fd0, fd1, fd2, fd3;
  logic        rclk0, rclk1, rclk2, rclk3;
  logic        sclk0, sclk1, sclk2, sclk3;
  logic        ser0, ser1, ser2, ser3;

  int n_checks = 0;
  int n_errors = 0;

  seg7_serial_display #(.DIGITS(2), .CLKDIV(4), .CONTINUOUS(0), .SEG_INVERT(0)) u0 (
    .eclk(eclk), .reset(reset), .hex(hex0), .dp(dp0), .blank(blank0), .load(load0),
    .busy(busy0), .frame_done(fd0), .rclk(rclk0), .sclk(sclk0), .ser(ser0));

  seg7_serial_display #(.DIGITS(2), .CLKDIV(4), .CONTINUOUS(0), .SEG_INVERT(1)) u1 (
    .eclk(eclk), .reset(reset), .hex(hex1), .dp(dp1), .blank(blank1), .load(load1),
    .busy(busy1), .frame_done(fd1), .rclk(rclk1), .sclk(sclk1), .ser(ser1));

  seg7_serial_display #(.DIGITS(2), .CLKDIV(4), .CONTINUOUS(1), .SEG_INVERT(0)) u2 (
    .eclk(eclk), .reset(reset), .hex(hex2), .dp(dp2), .blank(blank2), .load(load2),
    .busy(busy2), .frame_done(fd2), .rclk(rclk2), .sclk(sclk2), .ser(ser2));

  seg7_serial_display #(.DIGITS(4), .CLKDIV(2), .CONTINUOUS(0), .SEG_INVERT(0)) u3 (
    .eclk(eclk), .reset(reset), .hex(hex3), .dp(dp3), .blank(blank3), .load(load3),
    .busy(busy3), .frame_done(fd3), .rclk(rclk3), .sclk(sclk3), .ser(ser3));

  // Model of the external 74HC595 chain: shift on sclk rise, latch on rclk rise.
  logic [15:0] sh0, sh1, sh2, latched0, latched1, latched2;
  logic [31:0] sh3, latched3;
  int sclk_cnt0 = 0;
  int rclk_cnt0 = 0;

  always @(posedge sclk0) begin sh0 <= {sh0[14:0], ser0}; sclk_cnt0++; end
  always @(posedge rclk0) begin latched0 <= sh0; rclk_cnt0++; end
  always @(posedge sclk1) sh1 <= {sh1[14:0], ser1};
  always @(posedge rclk1) latched1 <= sh1;
  always @(posedge sclk2) sh2 <= {sh2[14:0], ser2};
  always @(posedge rclk2) latched2 <= sh2;
  always @(posedge sclk3) sh3 <= {sh3[30:0], ser3};
  always @(posedge rclk3) latched3 <= sh3;

  task automatic step();
    @(posedge eclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Pulses load0 for one edge with the given digit inputs; returns at cycle 0
  // of the frame (just after the start edge).
  task automatic applyStimulus(input logic [7:0] h, input logic [1:0] d,
                               input logic [1:0] b);
    hex0   = h;
    dp0    = d;
    blank0 = b;
    load0  = 1'b1;
    step();
    load0  = 1'b0;
  endtask

  // Checks {busy,frame_done,rclk,sclk,ser} of u0 for cycles 1..68 of a frame
  // whose shifted bits are 'bits'. CLKDIV=4: bit c/4, sclk high at c%4>=2,
  // latch during 64..67, frame_done at 68.
  task automatic frame_check(input logic [15:0] bits, input logic chained,
                             input logic next_ser, input logic pulse_loads,
                             input string tag);
    logic [4:0] exp;
    for (int c = 1; c <= 68; c++) begin
      load0 = pulse_loads && (c == 11 || c == 21 || c == 31);
      if (pulse_loads && c == 11) hex0 = 8'h23;
      step();
      if (c < 64)
        exp = {1'b1, 1'b0, 1'b0, ((c % 4) >= 2), bits[15 - c/4]};
      else if (c < 68)
        exp = {1'b1, 1'b0, 1'b1, 1'b0, bits[0]};
      else
        exp = {chained, 1'b1, 1'b0, 1'b0, (chained ? next_ser : bits[0])};
      checkOutput($sformatf("%s c%0d", tag, c),
                  {27'd0, busy0, fd0, rclk0, sclk0, ser0}, {27'd0, exp});
    end
    load0 = 1'b0;
  endtask

  initial begin
    int n;
    int busy_low;
    int rc;

    reset = 1'b0;
    hex0 = 8'h00; dp0 = 2'b00; blank0 = 2'b00; load0 = 1'b0;
    hex1 = 8'h00; dp1 = 2'b00; blank1 = 2'b00; load1 = 1'b0;
    hex2 = 8'h1A; dp2 = 2'b00; blank2 = 2'b00; load2 = 1'b0;
    hex3 = 16'h0000; dp3 = 4'h0; blank3 = 4'h0; load3 = 1'b0;

    // Reset state
    #12;
    checkOutput("reset u0", {27'd0, busy0, fd0, rclk0, sclk0, ser0}, 32'd0);
    checkOutput("reset u2", {27'd0, busy2, fd2, rclk2, sclk2, ser2}, 32'd0);
    checkOutput("reset u3", {27'd0, busy3, fd3, rclk3, sclk3, ser3}, 32'd0);
    @(negedge eclk);
    reset = 1'b1;
    step();

    // One-shot frame, hex 1A -> 06 77, true polarity
    $display("[TB] one-shot frame");
    sclk_cnt0 = 0;
    applyStimulus(8'h1A, 2'b00, 2'b00);
    checkOutput("t1 c0", {27'd0, busy0, fd0, rclk0, sclk0, ser0}, 32'b10000);
    frame_check(16'h0677, 1'b0, 1'b0, 1'b0, "t1");
    step();
    checkOutput("t1 idle", {27'd0, busy0, fd0, rclk0, sclk0, ser0}, 32'b00001);
    checkOutput("t1 sclk edges", sclk_cnt0, 32'd16);
    checkOutput("t1 latched", {16'd0, latched0}, 32'h0677);

    // Inverted polarity with dp and blank
    $display("[TB] inverted frame");
    hex1 = 8'h88; dp1 = 2'b10; blank1 = 2'b01; load1 = 1'b1;
    step();
    load1 = 1'b0;
    n = 0;
    while (fd1 !== 1'b1 && n < 100) begin step(); n++; end
    checkOutput("t2 frame len", n, 32'd68);
    checkOutput("t2 latched", {16'd0, latched1}, 32'h00FF);
    step();
    checkOutput("t2 busy after", {31'd0, busy1}, 32'd0);

    // Continuous refresh
    $display("[TB] continuous refresh");
    n = 0;
    while (fd2 !== 1'b1 && n < 100) begin step(); n++; end
    checkOutput("t4 first done", {31'd0, fd2}, 32'd1);
    n = 0; busy_low = 0;
    do begin step(); n++; if (busy2 !== 1'b1) busy_low++; end
    while (fd2 !== 1'b1 && n < 200);
    checkOutput("t4 period", n, 32'd68);
    hex2 = 8'h23;
    n = 0;
    do begin step(); n++; if (busy2 !== 1'b1) busy_low++; end
    while (fd2 !== 1'b1 && n < 200);
    checkOutput("t4 old data", {16'd0, latched2}, 32'h0677);
    n = 0;
    do begin step(); n++; if (busy2 !== 1'b1) busy_low++; end
    while (fd2 !== 1'b1 && n < 200);
    checkOutput("t4 new data", {16'd0, latched2}, 32'h5B4F);
    checkOutput("t4 busy low cycles", busy_low, 32'd0);

    // Four digits, leading zeros
    $display("[TB] four-digit frames");
    hex3 = 16'h0050; dp3 = 4'hF; load3 = 1'b1;
    step();
    load3 = 1'b0;
    n = 0;
    while (fd3 !== 1'b1 && n < 200) begin step(); n++; end
    checkOutput("t6 frame len", n, 32'd66);
`ifdef SEG7_LZ_BLANK_EN
    checkOutput("t6 0050", latched3, 32'h0000EDBF);
`else
    checkOutput("t6 0050", latched3, 32'hBFBFEDBF);
`endif
    step();
    checkOutput("t6 busy after", {31'd0, busy3}, 32'd0);
    hex3 = 16'h0000; load3 = 1'b1;
    step();
    load3 = 1'b0;
    n = 0;
    while (fd3 !== 1'b1 && n < 200) begin step(); n++; end
`ifdef SEG7_LZ_BLANK_EN
    checkOutput("t6 0000", latched3, 32'h000000BF);
`else
    checkOutput("t6 0000", latched3, 32'hBFBFBFBF);
`endif

    // Loads during a frame collapse into one pending frame with fresh data
    $display("[TB] pending frame");
    step();
    applyStimulus(8'h1A, 2'b00, 2'b00);
    checkOutput("t3 c0", {27'd0, busy0, fd0, rclk0, sclk0, ser0}, 32'b10000);
    frame_check(16'h0677, 1'b1, 1'b0, 1'b1, "t3a");
    frame_check(16'h5B4F, 1'b0, 1'b0, 1'b0, "t3b");
    step();
    checkOutput("t3 idle", {27'd0, busy0, fd0, rclk0, sclk0, ser0}, 32'b00001);
    checkOutput("t3 latched", {16'd0, latched0}, 32'h5B4F);

    // Reset in the middle of bit 9
    $display("[TB] reset mid-frame");
    step();
    applyStimulus(8'h23, 2'b00, 2'b00);
    for (int c = 1; c <= 36; c++) step();
    rc = rclk_cnt0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5 async clear", {27'd0, busy0, fd0, rclk0, sclk0, ser0}, 32'd0);
    step();
    checkOutput("t5 held", {27'd0, busy0, fd0, rclk0, sclk0, ser0}, 32'd0);
    #2;
    reset = 1'b1;
    step();
    step();
    checkOutput("t5 idle after", {27'd0, busy0, fd0, rclk0, sclk0, ser0}, 32'd0);
    checkOutput("t5 no rclk", rclk_cnt0, rc);
    applyStimulus(8'h23, 2'b00, 2'b00);
    checkOutput("t5 c0", {27'd0, busy0, fd0, rclk0, sclk0, ser0}, 32'b10000);
    frame_check(16'h5B4F, 1'b0, 1'b0, 1'b0, "t5");
    step();
    checkOutput("t5 latched", {16'd0, latched0}, 32'h5B4F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
